// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bundle: decoder/LUT inputs toward the sequencer and its
// registered PC/status outputs back toward instruction memory and the LUT.
interface pc_fetch_ctrl_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic             Start;
  logic             Halt;
  logic             BranchEn;
  logic             Taken;
  logic             Stall;
  logic [7:0]       Target;
  logic [1:0]       ProgState;
  logic [PC_W-1:0]  PC;
  logic             Running;
  logic             Done;
  logic [CNT_W-1:0] CycleCnt;

  modport master (
    output Start, Halt, BranchEn, Taken, Stall, Target,
    input  ProgState, PC, Running, Done, CycleCnt
  );

  modport slave (
    input  Start, Halt, BranchEn, Taken, Stall, Target,
    output ProgState, PC, Running, Done, CycleCnt
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program counter / fetch sequencer: steps through the test programs
// (IDLE -> RUN -> DONE -> RUN ...) and owns the LUT bank select.
module pc_fetch_ctrl #(
  parameter int PC_W     = 10,
  parameter int NUM_PROG = 3,
  parameter int START0   = 0,
  parameter int START1   = 256,
  parameter int START2   = 512,
  parameter int CNT_W    = 16
) (
  input  logic           Clk,
  input  logic           Reset,
  pc_fetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] LAST_PROG = 2'(NUM_PROG - 1);

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [1:0]       prog_q, prog_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [PC_W-1:0] start_pc(input logic [1:0] p);
    case (p)
      2'd1:    return PC_W'(START1);
      2'd2:    return PC_W'(START2);
      default: return PC_W'(START0);
    endcase
  endfunction

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      prog_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      prog_q  <= prog_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    prog_d  = prog_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          // an out-of-range bank select can only appear if forced; fold it to 0
          prog_d  = (prog_q > LAST_PROG) ? 2'd0 : prog_q;
          pc_d    = start_pc(prog_d);
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        if (bus.Halt)
          state_d = DONE;
        else if (bus.Stall)
          pc_d = pc_q;
        else if (bus.BranchEn && bus.Taken)
          pc_d = PC_W'(bus.Target);
        else
          pc_d = pc_q + 1'b1;
      end
      DONE: begin
        if (bus.Start) begin
          prog_d  = (prog_q >= LAST_PROG) ? 2'd0 : prog_q + 2'd1;
          pc_d    = start_pc(prog_d);
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ProgState = prog_q;
  assign bus.PC        = pc_q;
  assign bus.Running   = (state_q == RUN);
  assign bus.Done      = (state_q == DONE);
  assign bus.CycleCnt  = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus random stimulus, all
// checked against a transaction-level model of the program sequencer.
module tb_pc_fetch_ctrl;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic start = 0, halt = 0, br = 0, taken = 0, stall = 0;
  logic [7:0] target = '0;

  int n_cmp = 0;
  int n_fail = 0;

  // model: mode 0=idle 1=run 2=done
  int m_mode, m_pc, m_prog, m_cnt, m_cnt4;

  pc_fetch_ctrl_if #(.PC_W(10), .CNT_W(16)) bus  ();
  pc_fetch_ctrl_if #(.PC_W(10), .CNT_W(4))  bus4 ();

  assign bus.Start = start;    assign bus4.Start = start;
  assign bus.Halt = halt;      assign bus4.Halt = halt;
  assign bus.BranchEn = br;    assign bus4.BranchEn = br;
  assign bus.Taken = taken;    assign bus4.Taken = taken;
  assign bus.Stall = stall;    assign bus4.Stall = stall;
  assign bus.Target = target;  assign bus4.Target = target;

  pc_fetch_ctrl #(.PC_W(10), .CNT_W(16)) dut  (.Clk(Clk), .Reset(Reset), .bus(bus.slave));
  pc_fetch_ctrl #(.PC_W(10), .CNT_W(4))  dut4 (.Clk(Clk), .Reset(Reset), .bus(bus4.slave));

  always #5 Clk = ~Clk;

  function automatic logic [29:0] got_vec();
    return {bus.ProgState, bus.PC, bus.Running, bus.Done, bus.CycleCnt};
  endfunction

  function automatic logic [29:0] exp_vec();
    return {2'(m_prog), 10'(m_pc), m_mode == 1, m_mode == 2, 16'(m_cnt)};
  endfunction

  task automatic model_clear();
    m_mode = 0; m_pc = 0; m_prog = 0; m_cnt = 0; m_cnt4 = 0;
  endtask

  task automatic model_step();
    case (m_mode)
      0: if (start) begin
        m_pc = m_prog * 256; m_cnt = 0; m_cnt4 = 0; m_mode = 1;
      end
      1: begin
        m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        m_cnt4 = (m_cnt4 < 15) ? m_cnt4 + 1 : m_cnt4;
        if (halt) m_mode = 2;
        else if (stall) m_pc = m_pc;
        else if (br && taken) m_pc = target;
        else m_pc = (m_pc + 1) % 1024;
      end
      default: if (start) begin
        m_prog = (m_prog + 1) % 3;
        m_pc = m_prog * 256; m_cnt = 0; m_cnt4 = 0; m_mode = 1;
      end
    endcase
  endtask

  task automatic idle_in();
    start = 0; halt = 0; br = 0; taken = 0; stall = 0; target = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    Reset = 0;
    model_clear();
    @(posedge Clk);
    #1;
    Reset = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (got_vec() !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=%h", got_vec(), 30'd0);
    end
  endtask

  task automatic test_start_run();
    do_reset();
    start = 1; tick(); start = 0;
    for (int i = 0; i <= 5; i++) begin
      n_cmp++;
      if (bus.PC !== 10'(i) || got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL start_seq[%0d] got=%h exp=%h", i, got_vec(), exp_vec());
      end
      if (i < 5) tick();
    end
    n_cmp++;
    if (bus.CycleCnt !== 16'd5 || bus.Running !== 1'b1) begin
      n_fail++;
      $display("FAIL start_cnt got cnt=%0d run=%b exp cnt=5 run=1", bus.CycleCnt, bus.Running);
    end
  endtask

  task automatic test_branch();
    do_reset();
    start = 1; tick(); start = 0;
    repeat (3) tick();
    br = 1; taken = 1; target = 8'hA5; tick(); idle_in();
    n_cmp++;
    if (bus.PC !== 10'd165 || got_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL branch_taken got=%0d exp=165", bus.PC);
    end
    br = 1; taken = 1; target = 8'd3; tick(); idle_in();
    br = 1; taken = 0; target = 8'hEE; tick(); idle_in();
    n_cmp++;
    if (bus.PC !== 10'd4 || got_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL branch_not_taken got=%0d exp=4", bus.PC);
    end
    br = 0; taken = 1; target = 8'h77; tick(); idle_in();
    n_cmp++;
    if (bus.PC !== 10'd5) begin
      n_fail++;
      $display("FAIL taken_without_branch got=%0d exp=5", bus.PC);
    end
    br = 0; taken = 1; target = 8'bx; tick(); idle_in();
    n_cmp++;
    if (bus.PC !== 10'd6) begin
      n_fail++;
      $display("FAIL x_target got=%b exp=6", bus.PC);
    end
  endtask

  task automatic test_stall();
    int c0;
    br = 1; taken = 1; target = 8'd10; tick(); idle_in();
    c0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      stall = 1; tick(); idle_in();
      n_cmp++;
      if (bus.PC !== 10'd10 || got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got=%0d exp=10", i, bus.PC);
      end
    end
    n_cmp++;
    if (int'(bus.CycleCnt) !== c0 + 3) begin
      n_fail++;
      $display("FAIL stall_cnt got=%0d exp=%0d", bus.CycleCnt, c0 + 3);
    end
    tick();
    n_cmp++;
    if (bus.PC !== 10'd11) begin
      n_fail++;
      $display("FAIL stall_release got=%0d exp=11", bus.PC);
    end
    br = 1; taken = 1; target = 8'd10; tick(); idle_in();
    stall = 1; br = 1; taken = 1; target = 8'h20; tick(); idle_in();
    n_cmp++;
    if (bus.PC !== 10'd10 || got_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL stall_taken got=%0d exp=10", bus.PC);
    end
  endtask

  task automatic test_halt_progs();
    int exp_pc[3] = '{256, 512, 0};
    br = 1; taken = 1; target = 8'd12; tick(); idle_in();
    halt = 1; start = 1; br = 1; taken = 1; target = 8'h40; tick(); idle_in();
    n_cmp++;
    if (bus.Done !== 1'b1 || bus.PC !== 10'd12 || got_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL halt got done=%b pc=%0d exp done=1 pc=12", bus.Done, bus.PC);
    end
    repeat (2) tick();
    n_cmp++;
    if (got_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL done_hold got=%h exp=%h", got_vec(), exp_vec());
    end
    for (int k = 0; k < 3; k++) begin
      start = 1; tick(); idle_in();
      n_cmp++;
      if (bus.ProgState !== 2'((k + 1) % 3) || bus.PC !== 10'(exp_pc[k]) ||
          bus.Running !== 1'b1 || bus.Done !== 1'b0 || got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL prog_adv[%0d] got ps=%0d pc=%0d exp ps=%0d pc=%0d",
                 k, bus.ProgState, bus.PC, (k + 1) % 3, exp_pc[k]);
      end
      tick();
      if (k < 2) begin halt = 1; tick(); idle_in(); end
    end
  endtask

  task automatic test_wrap_sat();
    halt = 1; tick(); idle_in();
    start = 1; tick(); idle_in();
    halt = 1; tick(); idle_in();
    start = 1; tick(); idle_in();
    for (int i = 0; i < 511; i++) begin
      tick();
      if (i % 64 == 0 || i == 510) begin
        n_cmp++;
        if (got_vec() !== exp_vec() || int'(bus4.CycleCnt) !== m_cnt4) begin
          n_fail++;
          $display("FAIL wrap_run[%0d] got=%h/%0d exp=%h/%0d",
                   i, got_vec(), bus4.CycleCnt, exp_vec(), m_cnt4);
        end
      end
    end
    n_cmp++;
    if (bus.PC !== 10'd1023 || bus4.CycleCnt !== 4'd15) begin
      n_fail++;
      $display("FAIL pre_wrap got pc=%0d cnt4=%0d exp pc=1023 cnt4=15", bus.PC, bus4.CycleCnt);
    end
    tick();
    n_cmp++;
    if (bus.PC !== 10'd0 || bus4.CycleCnt !== 4'd15 || bus.CycleCnt !== 16'd512) begin
      n_fail++;
      $display("FAIL wrap got pc=%0d cnt4=%0d cnt=%0d exp pc=0 cnt4=15 cnt=512",
               bus.PC, bus4.CycleCnt, bus.CycleCnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    start = 1; tick(); idle_in();
    br = 1; taken = 1; target = 8'd37; tick(); idle_in();
    #3;
    Reset = 0;
    model_clear();
    #1;
    n_cmp++;
    if (got_vec() !== 30'd0 || bus4.CycleCnt !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset got=%h exp=0", got_vec());
    end
    @(posedge Clk); #1;
    Reset = 1;
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 5) == 0);
      halt  = ($urandom_range(0, 31) == 0);
      stall = ($urandom_range(0, 7) == 0);
      br    = ($urandom_range(0, 3) == 0);
      taken = 1'($urandom);
      target = br ? 8'($urandom) : 8'bx;
      tick();
      n_cmp++;
      if (got_vec() !== exp_vec() || int'(bus4.CycleCnt) !== m_cnt4) begin
        n_fail++;
        if (bad++ < 5)
          $display("FAIL random[%0d] got=%h exp=%h", i, got_vec(), exp_vec());
      end
    end
    idle_in();
  endtask

  initial begin
    test_reset();
    test_start_run();
    test_branch();
    test_stall();
    test_halt_progs();
    test_wrap_sat();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
